fifo_rr_sched: RTL and testbench
================================

# fifo_rr_sched

Round-robin read scheduler that drains N FWFT `fifo_sync` instances into one registered valid/ready output stream. It grants one queue at a time for a burst of up to BURST words, then rotates to the next non-empty queue. It sits between a bank of per-source FIFOs and a single shared downstream consumer. Queue selection can optionally be biased by the per-queue programmable-full flags.

## Interface
Parameters:
- `N`, 4, number of queues (2..16).
- `QW`, 2, queue-id width; must equal ceil(log2(N)).
- `DW`, 8, data width; matches the FIFO instances.
- `BURST`, 4, maximum words popped per grant (1..255).

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — reset, asynchronous assert, active-low.
- `q_empty`  in  N  — per-queue FWFT empty flag.
- `q_progfull`  in  N  — per-queue programmable-full flag; used only with the priority feature.
- `q_dout`  in  N*DW  — per-queue FWFT head word; queue k occupies bits [k*DW +: DW].
- `q_rd_en`  out  N  — per-queue pop strobe; combinational, one-hot or zero.
- `m_data`  out  DW  — output word (registered).
- `m_qid`  out  QW  — source queue of `m_data` (registered).
- `m_valid`  out  1  — output word valid (registered).
- `m_ready`  in  1  — downstream accept.
- `busy`  out  1  — high while in state SERVE.

## Operation
- FSM states are IDLE and SERVE. Registers are `gnt` (QW bits), `last` (QW bits) and `cnt` (8 bits).
- IDLE:
  - Search queues `last+1, last+2, …` modulo N for the first one with `q_empty` low.
  - If one is found: `gnt` takes its index, `cnt` clears to 0, go to SERVE.
  - Otherwise stay in IDLE.
- SERVE:
  - `pop = !q_empty[gnt] && (!m_valid || m_ready)`.
  - `q_rd_en[gnt] = pop`; all other bits of `q_rd_en` are 0. `q_rd_en` is always 0 in IDLE.
  - On `pop`: `m_data` takes `q_dout[gnt]`, `m_qid` takes `gnt`, `m_valid` is set, and `cnt` increments.
  - On `pop` with `cnt == BURST-1`: go to IDLE and set `last` to `gnt`.
  - On `q_empty[gnt]` high with no pop: go to IDLE and set `last` to `gnt`. The queue forfeits the rest of its burst.
- Output register:
  - `m_valid` clears when `m_ready` is high and no pop occurs that cycle.
  - `m_data` and `m_qid` hold their value while `m_valid && !m_ready`.
- Pops never occur while the output register is occupied and stalled. No word is lost or duplicated.
- Every IDLE visit costs exactly one cycle, so consecutive grants are separated by a 1-cycle gap.
- `cnt` wrap is unreachable because BURST ≤ 255.
- Reset values:
  - State IDLE; `last = N-1`, so queue 0 has first turn.
  - `gnt = 0`, `cnt = 0`.
  - `m_valid = 0`, `m_data = 0`, `m_qid = 0`, `busy = 0`.
  - `q_rd_en = 0`, since it is combinational from state.
- Reset mid-burst: all of the above is restored immediately on `rst_n` fall. Any pending output word is discarded.

## Timing
- The scheduler relies on each FIFO deasserting `q_empty` only when its head word is valid (FWFT). It also relies on `q_empty` being accurate in the cycle after a pop.
- Latency:
  - Queue goes non-empty with the scheduler in IDLE → grant on the next edge → first `q_rd_en` in the following cycle.
  - `m_valid` rises one edge after that `q_rd_en`.
- Throughput is 1 word/cycle within a burst when `m_ready` is held high.
- Sustained throughput with all queues busy is BURST/(BURST+1).
- If `m_ready` is low, `q_rd_en` stays 0 while `m_valid` is high. Popping resumes in the same cycle `m_ready` rises.

## Configuration
- `FIFO_SCHED_PRIO_EN` defined:
  - In IDLE, the round-robin search first considers only queues with `q_progfull && !q_empty`.
  - It falls back to all non-empty queues only if no such queue exists.
  - Rotation order and the `last` update are unchanged.
- `FIFO_SCHED_PRIO_EN` undefined: `q_progfull` is ignored, and selection is plain round-robin over non-empty queues.

## Test plan
- Reset with all queues empty → `m_valid = 0`, `q_rd_en = 0`, `busy = 0`; release reset → state stays IDLE and no pops occur.
- N=4, BURST=4, queues 0–3 each hold 10 words, `m_ready` = 1 → output `m_qid` sequence is 0,0,0,0,1,1,1,1,2,… with a 1-cycle gap between bursts; all 40 words are delivered in FIFO order.
- Queue 2 holds 2 words, all others empty → 2 words are output with `m_qid = 2`; the scheduler returns to IDLE after the empty flag rises, and `last = 2`.
- Hold `m_ready` = 0 for 5 cycles mid-burst → `m_data` is stable, `q_rd_en` = 0 throughout, and no word is dropped after `m_ready` returns to 1.
- With `FIFO_SCHED_PRIO_EN`, `last = 0`, queues 1 and 3 non-empty, only `q_progfull[3]` = 1 → the next grant goes to queue 3. Without the macro → the next grant goes to queue 1.
- Assert `rst_n` = 0 in the middle of a burst from queue 1 → `m_valid`, `q_rd_en` and `busy` drop immediately; after release, queue 0 is served first if it is non-empty.

Source files
------------

// File: rtl/fifo_rr_sched.sv
// fifo_rr_sched: round-robin read scheduler draining N FWFT FIFOs into one
// registered valid/ready stream, granting one queue per burst of up to BURST
// words. Optional build macro FIFO_SCHED_PRIO_EN biases each grant decision
// toward queues whose programmable-full flag is set.
module fifo_rr_sched #(
  parameter int N     = 4,
  parameter int QW    = 2,
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    q_empty,
  input  logic [N-1:0]    q_progfull,
  input  logic [N*DW-1:0] q_dout,
  output logic [N-1:0]    q_rd_en,
  output logic [DW-1:0]   m_data,
  output logic [QW-1:0]   m_qid,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            busy
);

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [QW-1:0]   gnt_q, gnt_d;
  logic [QW-1:0]   last_q, last_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [DW-1:0]   data_q, data_d;
  logic [QW-1:0]   qid_q, qid_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   head;
  logic            pop;
  logic [QW:0]     sel;

  // Returns {found, index} of the first requester after 'last' in rotation.
  // Iterating from the far end lets the nearest requester win.
  function automatic logic [QW:0] rr_pick(input logic [N-1:0] req,
                                          input logic [QW-1:0] last);
    logic [QW:0]   res;
    logic [QW-1:0] idx;
    res = '0;
    for (int i = N; i >= 1; i--) begin
      idx = QW'((int'(last) + i) % N);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef FIFO_SCHED_PRIO_EN
  logic [QW:0] prio_sel;
  logic [QW:0] any_sel;
  assign prio_sel = rr_pick(~q_empty & q_progfull, last_q);
  assign any_sel  = rr_pick(~q_empty, last_q);
  assign sel      = prio_sel[QW] ? prio_sel : any_sel;
`else
  logic unused_progfull;
  assign unused_progfull = ^q_progfull;
  assign sel             = rr_pick(~q_empty, last_q);
`endif

  // A pop needs a valid head on the granted queue and room in the output register.
  assign pop = (state_q == SERVE) && !q_empty[gnt_q] && (!valid_q || m_ready);

  // State register: FSM state, grant, rotation pointer and burst counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= QW'(N - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: one IDLE cycle per grant; a burst ends on BURST pops or an empty queue.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sel[QW]) begin
          gnt_d   = sel[QW-1:0];
          cnt_d   = '0;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (pop) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(BURST - 1)) begin
            state_d = IDLE;
            last_d  = gnt_q;
          end
        end else if (q_empty[gnt_q]) begin
          state_d = IDLE;
          last_d  = gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: pop strobe, busy flag and next value of the output register.
  always_comb begin
    q_rd_en = '0;
    busy    = (state_q == SERVE);
    head    = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_q == QW'(k)) head = q_dout[k*DW +: DW];
    end
    if (pop) q_rd_en[gnt_q] = 1'b1;
    valid_d = valid_q;
    data_d  = data_q;
    qid_d   = qid_q;
    if (pop) begin
      valid_d = 1'b1;
      data_d  = head;
      qid_d   = gnt_q;
    end else if (m_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register: reset discards any pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      qid_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      qid_q   <= qid_d;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign m_qid   = qid_q;

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Self-checking bench for fifo_rr_sched: behavioural FWFT FIFOs feed the DUT,
// a transaction-level round-robin model predicts the output word order.
module tb_fifo_rr_sched;
  localparam int N     = 4;
  localparam int QW    = 2;
  localparam int DW    = 8;
  localparam int BURST = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    q_empty;
  logic [N-1:0]    q_progfull;
  logic [N*DW-1:0] q_dout;
  logic [N-1:0]    q_rd_en;
  logic [DW-1:0]   m_data;
  logic [QW-1:0]   m_qid;
  logic            m_valid;
  logic            m_ready;
  logic            busy;

  fifo_rr_sched #(.N(N), .QW(QW), .DW(DW), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n), .q_empty(q_empty), .q_progfull(q_progfull),
    .q_dout(q_dout), .q_rd_en(q_rd_en), .m_data(m_data), .m_qid(m_qid),
    .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FWFT FIFOs
  logic [DW-1:0] mem [N][64];
  logic [7:0]    wr_ptr [N] = '{default: 8'd0};
  logic [7:0]    rd_ptr [N] = '{default: 8'd0};
  logic [N-1:0]  pop_s = '0;

  for (genvar k = 0; k < N; k++) begin : g_fifo
    assign q_empty[k]         = (rd_ptr[k] == wr_ptr[k]);
    assign q_dout[k*DW +: DW] = mem[k][rd_ptr[k][5:0]];
  end

  always @(posedge clk) begin
    for (int k = 0; k < N; k++)
      if (pop_s[k]) rd_ptr[k] <= rd_ptr[k] + 8'd1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          exp_cyc;
  int          m_last;
  bit          rdy_rand;
  bit          prev_stall;
  logic [DW-1:0] prev_data;
  logic [QW-1:0] prev_qid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: sample and check at negedge, return 2 time units after posedge.
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      chk("rden_onehot", 32'($onehot0(q_rd_en)), 32'd1);
      chk("rden_nonempty", 32'(q_rd_en & q_empty), 32'd0);
      if (!busy) chk("rden_idle", 32'(q_rd_en), 32'd0);
      if (m_valid && !m_ready) chk("rden_stall", 32'(q_rd_en), 32'd0);
      if (prev_stall) begin
        chk("hold_data", 32'(m_data), 32'(prev_data));
        chk("hold_qid", 32'(m_qid), 32'(prev_qid));
      end
      if (m_valid && m_ready) got_q.push_back(32'({m_qid, m_data}));
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_qid   = m_qid;
      pop_s      = q_rd_en;
    end else begin
      prev_stall = 1'b0;
      pop_s      = '0;
    end
    @(posedge clk);
    #2;
    if (rdy_rand) m_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic load(input int k, input int n);
    for (int j = 0; j < n; j++) begin
      mem[k][wr_ptr[k][5:0]] = 8'($urandom);
      wr_ptr[k] = wr_ptr[k] + 8'd1;
    end
  endtask

  // Reference: whole-burst round-robin over the current FIFO contents.
  task automatic build_expected();
    int  rem [N];
    int  base [N];
    int  cur;
    int  b;
    bit  lastfull;
    bit  done;
    exp_q.delete();
    exp_cyc  = 0;
    lastfull = 1'b0;
    done     = 1'b0;
    for (int k = 0; k < N; k++) begin
      rem[k]  = int'(8'(wr_ptr[k] - rd_ptr[k]));
      base[k] = int'(rd_ptr[k]);
    end
    for (int it = 0; it < 1000 && !done; it++) begin
      cur = -1;
`ifdef FIFO_SCHED_PRIO_EN
      for (int i = 1; i <= N; i++)
        if (cur < 0 && rem[(m_last + i) % N] > 0 && q_progfull[(m_last + i) % N])
          cur = (m_last + i) % N;
`endif
      for (int i = 1; i <= N; i++)
        if (cur < 0 && rem[(m_last + i) % N] > 0) cur = (m_last + i) % N;
      if (cur < 0) begin
        done = 1'b1;
      end else begin
        b = (rem[cur] < BURST) ? rem[cur] : BURST;
        for (int j = 0; j < b; j++)
          exp_q.push_back((32'(cur) << DW) | 32'(mem[cur][(base[cur] + j) % 64]));
        base[cur] += b;
        rem[cur]  -= b;
        exp_cyc   += 1 + b + ((b < BURST) ? 1 : 0);
        lastfull   = (b == BURST);
        m_last     = cur;
      end
    end
    if (lastfull) exp_cyc += 1;
  endtask

  task automatic wait_phase(input string tag, input int mark);
    int n;
    int cyc;
    n   = exp_q.size();
    cyc = 0;
    while (got_q.size() < mark + n && cyc < 3000) begin
      tick();
      cyc++;
    end
    chk({tag, "_timeout"}, 32'(cyc < 3000), 32'd1);
    for (int i = 0; i < n; i++)
      if (mark + i < got_q.size()) chk({tag, "_word"}, got_q[mark + i], exp_q[i]);
    repeat (6) tick();
    chk({tag, "_count"}, 32'(got_q.size()), 32'(mark + n));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_got(input string tag, input int target);
    int cyc;
    cyc = 0;
    while (got_q.size() < target && cyc < 500) begin
      tick();
      cyc++;
    end
    chk({tag, "_timeout"}, 32'(cyc < 500), 32'd1);
  endtask

  initial begin
    int mark;
    int cyc;
    logic [DW-1:0] saved;
    rst_n      = 1'b0;
    m_ready    = 1'b1;
    q_progfull = '0;
    rdy_rand   = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_qid   = '0;
    m_last     = N - 1;
    for (int k = 0; k < N; k++)
      for (int j = 0; j < 64; j++) mem[k][j] = '0;

    // Reset state with all queues empty
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_rden", 32'(q_rd_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_qid", 32'(m_qid), 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_nopop", 32'(got_q.size()), 32'd0);

    // Four queues of 10 words, m_ready held high: order and burst gaps
    for (int k = 0; k < N; k++) load(k, 10);
    build_expected();
    mark = got_q.size();
    cyc  = 0;
    while (got_q.size() < mark + exp_q.size() && cyc < 500) begin
      tick();
      cyc++;
    end
    chk("full_cycles", 32'(cyc), 32'(exp_cyc));
    wait_phase("full", mark);

    // Queue 2 alone with 2 words, then queues 1 and 3: rotation resumes after 2
    load(2, 2);
    build_expected();
    mark = got_q.size();
    wait_phase("q2only", mark);
    load(1, 1);
    load(3, 1);
    build_expected();
    mark = got_q.size();
    wait_phase("after2", mark);
    if (got_q.size() > mark) chk("after2_first", got_q[mark] >> DW, 32'd3);

    // Downstream stall for 5 cycles mid-burst
    load(0, 8);
    build_expected();
    mark = got_q.size();
    wait_got("stall_pre", mark + 2);
    m_ready = 1'b0;
    tick();
    saved = m_data;
    repeat (4) tick();
    chk("stall_valid", 32'(m_valid), 32'd1);
    chk("stall_hold", 32'(m_data), 32'(saved));
    m_ready = 1'b1;
    wait_phase("stall", mark);

    // last = 0, queues 1 and 3 pending, only queue 3 programmable-full
    q_progfull = 4'b1000;
    load(1, 2);
    load(3, 2);
    build_expected();
    mark = got_q.size();
    wait_phase("prio", mark);
`ifdef FIFO_SCHED_PRIO_EN
    if (got_q.size() > mark) chk("prio_first", got_q[mark] >> DW, 32'd3);
`else
    if (got_q.size() > mark) chk("prio_first", got_q[mark] >> DW, 32'd1);
`endif
    q_progfull = '0;

    // Reset in the middle of a burst from queue 1
    load(1, 8);
    mark = got_q.size();
    wait_got("rstmid_pre", mark + 2);
    if (got_q.size() > mark) chk("rstmid_pre_qid", got_q[mark] >> DW, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(m_valid), 32'd0);
    chk("rstmid_rden", 32'(q_rd_en), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_data", 32'(m_data), 32'd0);
    load(0, 3);
    tick();
    tick();
    rst_n  = 1'b1;
    m_last = N - 1;
    build_expected();
    mark = got_q.size();
    wait_phase("rstmid", mark);
    if (got_q.size() > mark) chk("rstmid_first", got_q[mark] >> DW, 32'd0);

    // Randomized fills, progfull patterns and back-pressure
    rdy_rand = 1'b1;
    for (int p = 0; p < 10; p++) begin
      q_progfull = N'($urandom);
      for (int k = 0; k < N; k++) load(k, $urandom_range(0, 9));
      build_expected();
      mark = got_q.size();
      wait_phase("rand", mark);
    end
    rdy_rand = 1'b0;
    m_ready  = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
